// File: rtl/maxpool2x2_stream_pkg.sv
// ============================================================================
// Module : maxpool_pkg
// Brief  : Shared widths, line-buffer geometry and FSM encoding for the
//          2x2 stride-2 fp16 max-pooling stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package maxpool_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int MAX_WIDTH  = 416;
    localparam int DIM_BITS   = 10;

    // One line-buffer entry per horizontal pixel pair
    localparam int LB_DEPTH = MAX_WIDTH / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);

    localparam logic [DATA_WIDTH-1:0] FP16_POS_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/maxpool2x2_stream_if.sv
// ============================================================================
// Module : maxpool2x2_stream_if
// Brief  : Pixel-in / pooled-pixel-out valid-ready stream bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface maxpool2x2_stream_if;
    import maxpool_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

`default_nettype wire

// File: rtl/maxpool2x2_stream_compare.sv
// ============================================================================
// Module : compare
// Brief  : Combinational fp16 max in sign-magnitude order; +0/-0 tie and
//          exact ties return the first operand. NaN/Inf are not special.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module compare #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_max
);

    // Maps values onto an unsigned scale; both zeros share one key
    function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] x);
        if (x[DATA_W-2:0] == '0)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else if (x[DATA_W-1])
            return ~x;
        else
            return {1'b1, x[DATA_W-2:0]};
    endfunction

    logic [DATA_W-1:0] w_key_a;
    logic [DATA_W-1:0] w_key_b;

    assign w_key_a = order_key(i_a);
    assign w_key_b = order_key(i_b);
    assign o_max   = (w_key_b > w_key_a) ? i_b : i_a;

endmodule

`default_nettype wire

// File: rtl/maxpool2x2_stream_linebuf.sv
// ============================================================================
// Module : maxpool_linebuf
// Brief  : Single-port half-row RAM, synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module maxpool_linebuf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 208,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/maxpool2x2_stream.sv
// ============================================================================
// Module : maxpool2x2_stream
// Brief  : Streaming 2x2 stride-2 fp16 max pool over a raster pixel stream.
//          Define MAXPOOL_FUSED_RELU_EN to clamp negative results to +0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module maxpool2x2_stream
    import maxpool_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIM_BITS-1:0] cfg_width,
    input  logic [DIM_BITS-1:0] cfg_height,
    maxpool2x2_stream_if.slave  bus,
    output logic                busy,
    output logic                done
);

    localparam logic [DIM_BITS-1:0] c_dim_one = DIM_BITS'(1);

    state_t                r_state;
    logic [DIM_BITS-1:0]   r_w;
    logic [DIM_BITS-1:0]   r_h;
    logic [DIM_BITS-1:0]   r_col;
    logic [DIM_BITS-1:0]   r_row;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_col_odd;
    logic                  w_row_odd;
    logic                  w_last_col;
    logic                  w_last_row;
    logic                  w_last_win;
    logic                  w_emit;
    logic                  w_lb_we;
    logic [LB_AW-1:0]      w_lb_addr;
    logic [DATA_WIDTH-1:0] w_lb_rdata;
    logic [DATA_WIDTH-1:0] w_hmax;
    logic [DATA_WIDTH-1:0] w_vmax;
    logic [DATA_WIDTH-1:0] w_pool;
    logic [DIM_BITS-1:0]   w_wp;
    logic [DIM_BITS-1:0]   w_hp;
    logic [DIM_BITS-1:0]   w_col_pair;
    logic [DIM_BITS-1:0]   w_row_pair;

    assign w_in_ready = (r_state == RUN) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_col_odd  = r_col[0];
    assign w_row_odd  = r_row[0];
    assign w_last_col = (r_col == r_w - c_dim_one);
    assign w_last_row = (r_row == r_h - c_dim_one);

    assign w_wp       = {1'b0, r_w[DIM_BITS-1:1]};
    assign w_hp       = {1'b0, r_h[DIM_BITS-1:1]};
    assign w_col_pair = {1'b0, r_col[DIM_BITS-1:1]};
    assign w_row_pair = {1'b0, r_row[DIM_BITS-1:1]};
    assign w_last_win = (w_col_pair == w_wp - c_dim_one) && (w_row_pair == w_hp - c_dim_one);

    // Odd columns close a horizontal pair; odd rows close the vertical pair.
    // A trailing odd column lands on an even column and a trailing odd row on
    // an even row, so neither can ever produce an output.
    assign w_lb_addr  = r_col[LB_AW:1];
    assign w_lb_we    = w_accept && w_col_odd && !w_row_odd;
    assign w_emit     = w_accept && w_col_odd && w_row_odd;

    compare #(.DATA_W(DATA_WIDTH)) u_hcmp (
        .i_a   (r_hold),
        .i_b   (bus.in_data),
        .o_max (w_hmax)
    );

    maxpool_linebuf #(
        .DATA_W (DATA_WIDTH),
        .DEPTH  (LB_DEPTH),
        .ADDR_W (LB_AW)
    ) u_linebuf (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_addr  (w_lb_addr),
        .i_wdata (w_hmax),
        .o_rdata (w_lb_rdata)
    );

    compare #(.DATA_W(DATA_WIDTH)) u_vcmp (
        .i_a   (w_lb_rdata),
        .i_b   (w_hmax),
        .o_max (w_vmax)
    );

`ifdef MAXPOOL_FUSED_RELU_EN
    assign w_pool = w_vmax[DATA_WIDTH-1] ? FP16_POS_ZERO : w_vmax;
`else
    assign w_pool = w_vmax;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_w         <= '0;
            r_h         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_hold      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (r_out_valid && bus.out_ready)
                r_out_valid <= 1'b0;
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_pool;
                r_out_last  <= w_last_win;
            end
            if (w_accept && !w_col_odd)
                r_hold <= bus.in_data;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_w     <= cfg_width;
                        r_h     <= cfg_height;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            if (w_last_row)
                                r_state <= DRAIN;
                            else
                                r_row <= r_row + c_dim_one;
                        end else begin
                            r_col <= r_col + c_dim_one;
                        end
                    end
                end
                DRAIN: begin
                    if (!r_out_valid || bus.out_ready) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_maxpool2x2_stream.sv
// ============================================================================
// Module : tb_maxpool2x2_stream
// Brief  : Scoreboard bench for maxpool2x2_stream: directed and random frames
//          checked against a window-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_maxpool2x2_stream;
    import maxpool_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [DIM_BITS-1:0] cfg_width = '0;
    logic [DIM_BITS-1:0] cfg_height = '0;
    logic                busy;
    logic                done;

    maxpool2x2_stream_if bus ();

    maxpool2x2_stream dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          out_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_hs_cyc = 0;
    int          frame_done0 = 0;
    int          frame_out0 = 0;
    int          rdy_mode = 0;
    bit          rdy_force = 1'b1;
    bit          bubbles = 1'b0;
    bit          sender_done = 1'b0;
    logic [16:0] exp_q [$];
    logic [15:0] pix [$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    // Numeric value of an fp16 word in sign-magnitude order (both zeros are 0)
    function automatic int fp_val(input logic [15:0] x);
        int v;
        v = int'(x[14:0]);
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] fmax(input logic [15:0] a, input logic [15:0] b);
        return (fp_val(b) > fp_val(a)) ? b : a;
    endfunction

    function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef MAXPOOL_FUSED_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic model_push(input int w, input int h);
        logic [15:0] top;
        logic [15:0] bot;
        for (int py = 0; py < h / 2; py++) begin
            for (int px = 0; px < w / 2; px++) begin
                top = fmax(pix[(2*py)*w + 2*px], pix[(2*py)*w + 2*px + 1]);
                bot = fmax(pix[(2*py+1)*w + 2*px], pix[(2*py+1)*w + 2*px + 1]);
                exp_q.push_back({(px == w/2 - 1) && (py == h/2 - 1), relu(fmax(top, bot))});
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1)
            bus.out_ready = ($urandom_range(0, 3) != 0);
        else if (rdy_mode == 2)
            bus.out_ready = rdy_force;
        else
            bus.out_ready = 1'b1;
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            out_cnt++;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_output", {15'd0, bus.out_last, bus.out_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("out_data", {16'd0, bus.out_data}, {16'd0, e[15:0]});
                check("out_last", {31'd0, bus.out_last}, {31'd0, e[16]});
            end
        end
        if (!rst && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h);
        frame_done0 = done_cnt;
        frame_out0  = out_cnt;
        cfg_width   = w[DIM_BITS-1:0];
        cfg_height  = h[DIM_BITS-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic send_n(input int n);
        sender_done = 1'b0;
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            if (bubbles && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) tick();
            bus.in_valid = 1'b1;
            bus.in_data  = pix[i];
            forever begin
                @(negedge clk);
                if (bus.in_ready) begin
                    tick();
                    break;
                end
                tick();
                guard++;
                if (guard > 2000) begin
                    check("in_ready_timeout", 32'd0, 32'd1);
                    break;
                end
            end
            bus.in_valid = 1'b0;
        end
        sender_done = 1'b1;
    endtask

    task automatic finish_frame(input int w, input int h, input bit chk_early);
        int guard = 0;
        if (chk_early)
            check("no_early_done", done_cnt, frame_done0);
        while (done_cnt == frame_done0 && guard < 2000) begin
            tick();
            guard++;
        end
        check("done_seen", done_cnt, frame_done0 + 1);
        tick();
        tick();
        check("done_single_pulse", done_cnt, frame_done0 + 1);
        check("out_count", out_cnt - frame_out0, (w / 2) * (h / 2));
        check("exp_q_empty", exp_q.size(), 0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_frame(input int w, input int h);
        start_frame(w, h);
        send_n(w * h);
        finish_frame(w, h, 1'b1);
    endtask

    function automatic logic [15:0] rand_pix();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h8000;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        logic [15:0] held;
        int          g;
        int          w;
        int          h;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_last",  {31'd0, bus.out_last},  32'd0);
        check("rst_out_data",  {16'd0, bus.out_data},  32'd0);
        check("rst_busy",      {31'd0, busy},          32'd0);
        check("rst_done",      {31'd0, done},          32'd0);

        // 4x2 directed frame
        pix = '{16'h3C00, 16'h4000, 16'h3800, 16'h3C00,
                16'hBC00, 16'h3800, 16'h4400, 16'hC000};
        exp_q.push_back({1'b0, 16'h4000});
        exp_q.push_back({1'b1, 16'h4400});
        run_frame(4, 2);
        check("done_after_last_out", done_cyc - last_hs_cyc, 32'd1);

        // All-negative 2x2 window
        pix = '{16'hBC00, 16'hC000, 16'hC400, 16'hBE00};
`ifdef MAXPOOL_FUSED_RELU_EN
        exp_q.push_back({1'b1, 16'h0000});
`else
        exp_q.push_back({1'b1, 16'hBC00});
`endif
        run_frame(2, 2);

        // Signed-zero tie: first operand wins at both stages
        pix = '{16'h8000, 16'h0000, 16'h8000, 16'h0000};
`ifdef MAXPOOL_FUSED_RELU_EN
        exp_q.push_back({1'b1, 16'h0000});
`else
        exp_q.push_back({1'b1, 16'h8000});
`endif
        run_frame(2, 2);

        // 5x3: odd column and odd row are accepted and dropped
        pix.delete();
        for (int i = 0; i < 15; i++) pix.push_back(rand_pix());
        model_push(5, 3);
        run_frame(5, 3);

        // Output stall while the next pixel is waiting
        pix.delete();
        for (int i = 0; i < 8; i++) pix.push_back(rand_pix());
        model_push(4, 2);
        rdy_mode  = 2;
        rdy_force = 1'b0;
        tick();
        start_frame(4, 2);
        fork
            send_n(8);
        join_none
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus.out_valid && g < 200);
        check("stall_valid_seen", {31'd0, bus.out_valid}, 32'd1);
        held = exp_q[0][15:0];
        repeat (10) begin
            @(negedge clk);
            check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_out_data",  {16'd0, bus.out_data},  {16'd0, held});
            check("stall_in_ready",  {31'd0, bus.in_ready},  32'd0);
        end
        @(posedge clk);
        #1;
        rdy_force     = 1'b1;
        bus.out_ready = 1'b1;
        g = 0;
        while (!sender_done && g < 2000) begin
            tick();
            g++;
        end
        check("stall_sender_done", {31'd0, sender_done}, 32'd1);
        finish_frame(4, 2, 1'b0);
        rdy_mode = 0;

        // Reset mid-frame after 5 pixels
        pix = '{16'h3C00, 16'h4000, 16'h3800, 16'h3C00,
                16'h4400, 16'h4400, 16'h4400, 16'h4400};
        start_frame(4, 2);
        send_n(5);
        rst = 1'b1;
        tick();
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_done",      {31'd0, done},          32'd0);
        check("midrst_busy",      {31'd0, busy},          32'd0);
        check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        pix = '{16'h3C00, 16'h4000, 16'h3800, 16'h3C00};
        exp_q.push_back({1'b1, 16'h4000});
        run_frame(2, 2);

        // Random frames with input bubbles and output backpressure
        rdy_mode = 1;
        bubbles  = 1'b1;
        repeat (8) begin
            w = $urandom_range(2, 12);
            h = $urandom_range(2, 6);
            pix.delete();
            for (int i = 0; i < w * h; i++) pix.push_back(rand_pix());
            model_push(w, h);
            run_frame(w, h);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage for fp16 feature-map channels.
- Sits directly upstream of the writeback and consumes the conv/activation pixel stream in raster order.
- Instantiates the existing combinational `compare` max unit for every pairwise fp16 max.
- Pairs of pixels are reduced horizontally, half-rows are buffered, and one pooled pixel is emitted per 2x2 window.

Parameters:
- DATA_WIDTH, 16: pixel width, fp16 (sign, 5-bit exp, 10-bit mantissa).
- MAX_WIDTH, 416: largest supported input row width in pixels.
- DIM_BITS, 10: width of the dimension configuration fields and counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- cfg_width  in  DIM_BITS  input row width, 2..MAX_WIDTH.
- cfg_height  in  DIM_BITS  input row count, >=2.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  input pixel.
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_WIDTH  pooled pixel.
- out_last  out  1  marks the final pooled pixel of the frame.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset: state=IDLE; in_ready, out_valid, out_last, busy and done are 0; out_data=0; counters=0. Line-buffer contents are don't-care.
- Reset mid-frame aborts the frame with no output. Any held output is dropped.
- States:
  - IDLE: on start, latch cfg_width/cfg_height, clear col/row, go to RUN. start is ignored in every other state.
  - RUN: accept pixels and advance col/row on each handshake. Accepting the last pixel (col=W-1, row=H-1) moves to DRAIN.
  - DRAIN: wait until the output register is empty or being read (!out_valid || out_ready), then pulse done for one cycle and return to IDLE.
- in_ready = (state==RUN) && (!out_valid || out_ready). A stall never loses or duplicates a pixel.
- Effective dimensions: Wp = floor(W/2), Hp = floor(H/2).
  - The trailing odd column pixel is accepted and discarded.
  - The trailing odd row is accepted and fully discarded.
- Even-column pixel (col[0]=0): stored in the hold register.
- Odd-column pixel: hmax = max(hold, in_data).
  - On even rows, hmax is written to linebuf[col>>1].
  - On odd rows, out_data <= max(linebuf[col>>1], hmax) and out_valid is set on the next clock edge.
- Latency: 1 cycle from the accepting edge of the window's bottom-right pixel.
- out_valid stays high until out_ready; out_data and out_last are held stable while stalled.
- out_last = 1 on the window at pooled position (Wp-1, Hp-1).
- Max semantics come from `compare`: sign-magnitude ordering.
  - Negative values are ordered by inverted magnitude.
  - +0 and -0 compare equal, and the first operand wins.
  - NaN and Inf are not special-cased.
- Line buffer: Wp entries used out of MAX_WIDTH/2, single-port, one read/write per accepted pixel. Infers as distributed or BRAM.
- col wraps to 0 at W-1 and row increments. row does not wrap; the frame ends at H-1.
- Pooled outputs per frame: exactly Wp*Hp.

Optional Feature:
- Macro: MAXPOOL_FUSED_RELU_EN.
- Defined: the pooled result is clamped, so any value with sign bit 1 (including -0) is output as 16'h0000.
- Undefined: raw max is output. Latency and handshakes are identical in both builds.

Decomposition:
- Shared package maxpool_pkg:
  - DATA_WIDTH, MAX_WIDTH, DIM_BITS.
  - State enum {IDLE, RUN, DRAIN}.
  - FP16_POS_ZERO constant.
- Natural sub-module: maxpool_linebuf, a parameterised single-port half-row RAM.
- The pairwise max reuses the existing `compare`, instantiated twice (horizontal and vertical).

Test Plan:
- 4x2 frame, rows [3C00,4000,3800,3C00] / [BC00,3800,4400,C000] -> out 4000 then 4400; out_last on the 2nd output; done 1 cycle after it is accepted.
- All-negative 2x2 [BC00,C000,C400,BE00] -> out BC00. With MAXPOOL_FUSED_RELU_EN -> 0000.
- 5x3 frame (odd W and H), 15 pixels accepted -> exactly 2 outputs.
  - 5th column and 3rd row are dropped.
  - done asserts after all 15 pixels are accepted.
- out_ready held low 10 cycles while the window completes:
  - out_valid and out_data stay stable.
  - in_ready stays 0 throughout.
  - No pixel is lost; the output count still equals Wp*Hp.
- Zero tie: window [8000,0000,8000,0000] -> out 8000, because the first operand wins.
- rst asserted mid-frame after 5 pixels:
  - Next cycle: IDLE, out_valid=0, done=0.
  - A new start followed by a 2x2 frame [3C00,4000,3800,3C00] -> out 4000.
